// File: rtl/idivf_if.sv
// idivf_if: operand/result bundle for the idivf iterative divider.
//   master : drives go, sign, bits, n, d; observes busy, q, r, ovf, dz
//   slave  : the divider itself
// WIDTH is the divisor/quotient/remainder width; the dividend is 2*WIDTH.
interface idivf_if #(parameter int WIDTH = 8);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               go;    // start strobe, honoured only while idle
  logic               sign;  // 1 = dividend is two's complement
  logic [BW-1:0]      bits;  // quotient bits to compute, minus one
  logic [2*WIDTH-1:0] n;     // dividend
  logic [WIDTH-1:0]   d;     // divisor, unsigned
  logic               busy;  // operation in progress
  logic [WIDTH-1:0]   q;     // quotient
  logic [WIDTH-1:0]   r;     // remainder
  logic               ovf;   // quotient does not fit, or divide by zero
  logic               dz;    // divide by zero

  modport master (output go, sign, bits, n, d,
                  input  busy, q, r, ovf, dz);
  modport slave  (input  go, sign, bits, n, d,
                  output busy, q, r, ovf, dz);
endinterface

// File: rtl/idivf.sv
// idivf: iterative restoring divider, 2W-bit dividend by W-bit unsigned
// divisor. Only the top bits+1 quotient bits are produced, one per clock,
// so a caller can trade precision for latency (companion of imultf).
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : idivf_if.slave -- go/sign/bits/n/d in, busy/q/r/ovf/dz out
// Flow: IDLE -> DIV (k cycles) -> FIX -> IDLE, or IDLE -> ERR -> IDLE when
// the quotient cannot fit or the divisor is zero. Results change only on
// the edge where busy falls and hold until the next completion.
module idivf #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  idivf_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_ERR} state_t;

  state_t state, state_nx;

  // Operand decode at go: magnitude, sign and the up-front overflow test.
  logic           neg_in;
  logic [2*W-1:0] m_in;
  logic [2*W-1:0] chk_in;
  logic           dz_in;
  logic           err_in;

  // Working registers of the divide loop.
  logic [W-1:0]  rem;     // partial remainder
  logic [W-1:0]  lo;      // dividend bits not yet brought down, MSB first
  logic [W-1:0]  qreg;    // quotient, filled MSB first
  logic [W-1:0]  d_r;
  logic [BW-1:0] bits_r;
  logic [BW-1:0] cnt;
  logic          neg_r;
  logic          dz_r;

  // One restoring step.
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          step_q;
  logic [W-1:0]  step_rem;
  logic [BW-1:0] q_idx;

  // Result registers.
  logic [W-1:0] q_r;
  logic [W-1:0] r_r;
  logic         ovf_r;
  logic         dz_o;

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave a signal unassigned and infer a latch.
  always_comb begin
    neg_in = bus.sign & bus.n[2*W-1];
    m_in   = neg_in ? -bus.n : bus.n;
    // Signed results must fit in W-1 magnitude bits, so the test shifts by
    // one less; this also rejects the exact -2^(W-1) quotient.
    chk_in = bus.sign ? (m_in >> (W-1)) : {{W{1'b0}}, m_in[2*W-1:W]};
    dz_in  = (bus.d == '0);
    err_in = dz_in | (chk_in >= {{W{1'b0}}, bus.d});
  end

  always_comb begin
    // The trial value is W+1 bits wide: rem < d, so after the shift it can
    // exceed 2^W and the top bit must take part in the compare.
    trial    = {rem, lo[W-1]};
    diff     = trial - {1'b0, d_r};
    step_q   = (trial >= {1'b0, d_r});
    step_rem = step_q ? diff[W-1:0] : trial[W-1:0];
    q_idx    = BW'(W-1) - cnt;
  end

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (bus.go) state_nx = err_in ? S_ERR : S_DIV;
      S_DIV:  if (cnt == bits_r) state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
      S_ERR:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: the loop registers carry no reset; they are fully loaded on go
  // before anything reads them, and the FSM alone decides when they matter.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.go) begin
      rem    <= m_in[2*W-1:W];
      lo     <= m_in[W-1:0];
      qreg   <= '0;
      d_r    <= bus.d;
      bits_r <= bus.bits;
      neg_r  <= neg_in;
      dz_r   <= dz_in;
      cnt    <= '0;
    end else if (state == S_DIV) begin
      rem         <= step_rem;
      lo          <= lo << 1;
      qreg[q_idx] <= step_q;
      cnt         <= cnt + BW'(1);
    end
  end

  // After k steps the unfilled low quotient bits are still zero and rem is
  // the remainder of (m >> s) / d, so the truncated result needs no shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      r_r   <= '0;
      ovf_r <= 1'b0;
      dz_o  <= 1'b0;
    end else begin
      unique case (state)
        S_FIX: begin
          // Truncate toward zero; the remainder follows the dividend sign.
          q_r   <= neg_r ? -qreg : qreg;
          r_r   <= neg_r ? -rem  : rem;
          ovf_r <= 1'b0;
          dz_o  <= 1'b0;
        end
        S_ERR: begin
          q_r   <= '1;
          r_r   <= '0;
          ovf_r <= 1'b1;
          dz_o  <= dz_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.q    = q_r;
  assign bus.r    = r_r;
  assign bus.ovf  = ovf_r;
  assign bus.dz   = dz_o;
endmodule
